// File: rtl/fp_divider_if.sv
// Operand/result handshake bundle for the iterative double-precision divider.
// The master drives operands and accepts results; the slave is the divider.
interface fp_divider_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/fp_divider.sv
// Iterative IEEE-754 double divider: restoring shift-subtract, one quotient bit
// per cycle, truncating result, subnormals flushed to zero.
module fp_divider #(
  parameter int BIAS  = 1023,
  parameter int QBITS = 54
) (
  input  logic       clk,
  input  logic       rst_n,
  fp_divider_if.slave bus
);

  localparam int          CW       = $clog2(QBITS);
  localparam logic [CW-1:0] LAST   = CW'(QBITS - 1);
  localparam logic [12:0] BIAS13   = 13'(BIAS);
  localparam logic [63:0] QNAN_ENC = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] INF_ENC  = 64'h7FF0_0000_0000_0000;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg;
  logic [QBITS:0]    rem_reg;
  logic [QBITS-1:0]  quo_reg;
  logic [52:0]       mb_reg;
  logic [10:0]       ea_reg, eb_reg;
  logic              sign_reg;
  logic [63:0]       out_reg;

  // Operand classification, shared structure for a (index 0) and b (index 1)
  logic [63:0] opnd [2];
  logic [1:0]  is_nan, is_inf, is_zero;

  assign opnd[0] = bus.a;
  assign opnd[1] = bus.b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_class
      assign is_nan[gi]  = (opnd[gi][62:52] == 11'h7FF) && (opnd[gi][51:0] != 52'd0);
      assign is_inf[gi]  = (opnd[gi][62:52] == 11'h7FF) && (opnd[gi][51:0] == 52'd0);
      assign is_zero[gi] = (opnd[gi][62:52] == 11'h000);
    end
  endgenerate

  logic        special;
  logic [63:0] special_val;

  always_comb begin
    special     = |{is_nan, is_inf, is_zero};
    special_val = 64'h0;
    if ((|is_nan) || (&is_inf) || (&is_zero))
      special_val = QNAN_ENC;
    else if (is_inf[0] || is_zero[1])
      special_val = INF_ENC;
    else
      special_val = 64'h0;
  end

  // One restoring step; remainder stays below 2*mb so the shifted-out MSB is always 0
  logic [QBITS:0] mb_ext, rem_sel, rem_next;
  logic           q_bit;

  always_comb begin
    mb_ext   = {{(QBITS - 52){1'b0}}, mb_reg};
    q_bit    = (rem_reg >= mb_ext);
    rem_sel  = q_bit ? (rem_reg - mb_ext) : rem_reg;
    rem_next = {rem_sel[QBITS-1:0], 1'b0};
  end

  logic signed [12:0] exp_raw, exp_adj;
  logic [51:0]        mant_norm;
  logic [63:0]        norm_result;

  always_comb begin
    exp_raw   = {2'b00, ea_reg} - {2'b00, eb_reg} + BIAS13;
    exp_adj   = quo_reg[QBITS-1] ? exp_raw : (exp_raw - 13'sd1);
    mant_norm = quo_reg[QBITS-1] ? quo_reg[QBITS-2:1] : quo_reg[QBITS-3:0];
    if (exp_adj >= 13'sd2047)
      norm_result = INF_ENC;
    else if (exp_adj <= 13'sd0)
      norm_result = 64'h0;
    else
      norm_result = {sign_reg, exp_adj[10:0], mant_norm};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.in_valid) state_next = special ? DONE : DIV;
      DIV:  if (count_reg == LAST) state_next = NORM;
      NORM: state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_reg == IDLE);
    bus.out_valid = (state_reg == DONE);
    bus.busy      = (state_reg != IDLE);
    bus.out       = out_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      mb_reg    <= '0;
      ea_reg    <= '0;
      eb_reg    <= '0;
      sign_reg  <= 1'b0;
      out_reg   <= 64'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            sign_reg  <= bus.a[63] ^ bus.b[63];
            ea_reg    <= bus.a[62:52];
            eb_reg    <= bus.b[62:52];
            mb_reg    <= {1'b1, bus.b[51:0]};
            rem_reg   <= {{(QBITS - 52){1'b0}}, 1'b1, bus.a[51:0]};
            quo_reg   <= '0;
            count_reg <= '0;
            if (special)
              out_reg <= special_val;
          end
        end
        DIV: begin
          rem_reg   <= rem_next;
          quo_reg   <= {quo_reg[QBITS-2:0], q_bit};
          count_reg <= count_reg + CW'(1);
        end
        NORM: out_reg <= norm_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Bench for fp_divider: directed vectors, randomized operands against an
// integer-division reference model, backpressure, mid-run reset and back-to-back.
module tb_fp_divider;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  fp_divider_if dif ();

  fp_divider #(.BIAS(1023), .QBITS(54)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int NDIR = 12;
  logic [63:0] dir_a   [NDIR] = '{64'h4018000000000000, 64'h3FF0000000000000, 64'hBFF8000000000000,
                                  64'h3FF0000000000000, 64'h0000000000000000, 64'h0000000000000000,
                                  64'h7FF0000000000000, 64'h7FE0000000000000, 64'h0010000000000000,
                                  64'h7FF8000000000000, 64'hFFF0000000000000, 64'h0000000000000001};
  logic [63:0] dir_b   [NDIR] = '{64'h4000000000000000, 64'h4008000000000000, 64'h3FE0000000000000,
                                  64'h0000000000000000, 64'h0000000000000000, 64'h4014000000000000,
                                  64'h7FF0000000000000, 64'h3FE0000000000000, 64'h4000000000000000,
                                  64'h3FF0000000000000, 64'h4000000000000000, 64'hC000000000000000};
  logic [63:0] dir_exp [NDIR] = '{64'h4008000000000000, 64'h3FD5555555555555, 64'hC008000000000000,
                                  64'h7FF0000000000000, 64'h7FFFFFFFFFFFFFFF, 64'h0000000000000000,
                                  64'h7FFFFFFFFFFFFFFF, 64'h7FF0000000000000, 64'h0000000000000000,
                                  64'h7FFFFFFFFFFFFFFF, 64'h7FF0000000000000, 64'h0000000000000000};
  int          dir_lat [NDIR] = '{56, 56, 56, 1, 1, 1, 1, 56, 56, 1, 1, 1};

  // Reference: special-case table, then exact integer quotient of the significands
  function automatic void model_div(input logic [63:0] x, input logic [63:0] y,
                                    output logic [63:0] r, output int lat);
    int           ex, ey, e;
    logic         xn, xi, xz, yn, yi, yz;
    logic [106:0] num, den, q;
    logic [51:0]  mr;
    ex = int'(x[62:52]);
    ey = int'(y[62:52]);
    xn = (ex == 2047) && (x[51:0] != 0);
    xi = (ex == 2047) && (x[51:0] == 0);
    xz = (ex == 0);
    yn = (ey == 2047) && (y[51:0] != 0);
    yi = (ey == 2047) && (y[51:0] == 0);
    yz = (ey == 0);
    lat = 1;
    if (xn || yn || (xi && yi) || (xz && yz)) r = 64'h7FFFFFFFFFFFFFFF;
    else if (xi || yz)                       r = 64'h7FF0000000000000;
    else if (xz || yi)                       r = 64'h0;
    else begin
      lat = 56;
      num = {54'd0, 1'b1, x[51:0]};
      num = num << 53;
      den = {54'd0, 1'b1, y[51:0]};
      q   = num / den;
      e   = ex - ey + 1023;
      if (q[53]) mr = q[52:1];
      else begin
        mr = q[51:0];
        e  = e - 1;
      end
      if (e >= 2047)   r = 64'h7FF0000000000000;
      else if (e <= 0) r = 64'h0;
      else             r = {x[63] ^ y[63], e[10:0], mr};
    end
  endfunction

  function automatic logic [63:0] rand_operand();
    logic [63:0] tmp;
    logic [51:0] man;
    logic [10:0] ex;
    int          r;
    tmp = {$urandom, $urandom};
    man = tmp[51:0];
    r   = int'($urandom_range(0, 99));
    if (r < 5)       man = 52'd0;
    if (r < 8)       ex = 11'd0;
    else if (r < 14) begin ex = 11'h7FF; man = 52'd0; end
    else if (r < 18) begin ex = 11'h7FF; man[0] = 1'b1; end
    else if (r < 28) ex = 11'($urandom_range(1, 2046));
    else             ex = 11'($urandom_range(723, 1323));
    return {tmp[63], ex, man};
  endfunction

  task automatic run_op(input logic [63:0] x, input logic [63:0] y,
                        output logic [63:0] res, output int lat);
    int guard;
    guard = 0;
    while (!dif.in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    dif.a = x; dif.b = y; dif.in_valid = 1'b1;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    dif.a = {$urandom, $urandom};
    dif.b = {$urandom, $urandom};
    lat = 1;
    while (!dif.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    res = dif.out;
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    $display("op a=%h b=%h out=%h lat=%0d", x, y, res, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dif.in_valid = 1'b0; dif.out_ready = 1'b0; dif.a = '0; dif.b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (dif.in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", dif.in_ready); end
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", dif.out_valid); end
    n_cmp++; if (dif.out !== 64'h0)      begin n_bad++; $display("FAIL reset_out got=%h want=0", dif.out); end
    n_cmp++; if (dif.busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got=%b want=0", dif.busy); end
  endtask

  task automatic test_directed();
    logic [63:0] res;
    int          lat;
    for (int i = 0; i < NDIR; i++) begin
      run_op(dir_a[i], dir_b[i], res, lat);
      n_cmp++; if (res !== dir_exp[i]) begin n_bad++; $display("FAIL directed_%0d_out got=%h want=%h", i, res, dir_exp[i]); end
      n_cmp++; if (lat != dir_lat[i])  begin n_bad++; $display("FAIL directed_%0d_latency got=%0d want=%0d", i, lat, dir_lat[i]); end
    end
  endtask

  task automatic test_random();
    logic [63:0] x, y, res, want;
    int          lat, want_lat;
    for (int i = 0; i < 40; i++) begin
      x = rand_operand();
      y = rand_operand();
      model_div(x, y, want, want_lat);
      run_op(x, y, res, lat);
      n_cmp++; if (res !== want)    begin n_bad++; $display("FAIL random_%0d_out a=%h b=%h got=%h want=%h", i, x, y, res, want); end
      n_cmp++; if (lat != want_lat) begin n_bad++; $display("FAIL random_%0d_latency got=%0d want=%0d", i, lat, want_lat); end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    dif.a = 64'h4018000000000000; dif.b = 64'h4000000000000000; dif.in_valid = 1'b1;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    guard = 1;
    while (!dif.out_valid && guard < 200) begin @(posedge clk); #1; guard++; end
    n_cmp++; if (guard != 56) begin n_bad++; $display("FAIL backpressure_latency got=%0d want=56", guard); end
    dif.in_valid = 1'b1; dif.a = 64'h3FF0000000000000; dif.b = 64'h4008000000000000;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (dif.out !== 64'h4008000000000000) begin n_bad++; $display("FAIL hold_%0d_out got=%h want=4008000000000000", c, dif.out); end
      n_cmp++; if (dif.out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_%0d_out_valid got=%b want=1", c, dif.out_valid); end
      n_cmp++; if (dif.in_ready !== 1'b0)  begin n_bad++; $display("FAIL hold_%0d_in_ready got=%b want=0", c, dif.in_ready); end
    end
    dif.in_valid = 1'b0;
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    $display("op backpressure a=4018000000000000 b=4000000000000000 held=10");
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int          lat;
    dif.a = 64'h4018000000000000; dif.b = 64'h4000000000000000; dif.in_valid = 1'b1;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_out_valid got=%b want=0", dif.out_valid); end
    n_cmp++; if (dif.in_ready !== 1'b1)  begin n_bad++; $display("FAIL midreset_in_ready got=%b want=1", dif.in_ready); end
    n_cmp++; if (dif.busy !== 1'b0)      begin n_bad++; $display("FAIL midreset_busy got=%b want=0", dif.busy); end
    n_cmp++; if (dif.out !== 64'h0)      begin n_bad++; $display("FAIL midreset_out got=%h want=0", dif.out); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(64'h4018000000000000, 64'h4000000000000000, res, lat);
    n_cmp++; if (res !== 64'h4008000000000000) begin n_bad++; $display("FAIL after_reset_out got=%h want=4008000000000000", res); end
    n_cmp++; if (lat != 56) begin n_bad++; $display("FAIL after_reset_latency got=%0d want=56", lat); end
  endtask

  task automatic test_back_to_back();
    int lat;
    dif.a = 64'h4008000000000000; dif.b = 64'h3FF8000000000000; dif.in_valid = 1'b1;
    @(posedge clk); #1;
    // Next operands presented immediately and held while the first is in flight
    dif.a = 64'h4018000000000000; dif.b = 64'h4000000000000000;
    lat = 1;
    while (!dif.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (dif.out !== 64'h4000000000000000) begin n_bad++; $display("FAIL b2b_first_out got=%h want=4000000000000000", dif.out); end
    n_cmp++; if (dif.in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_done_in_ready got=%b want=0", dif.in_ready); end
    $display("op b2b first a=4008000000000000 b=3FF8000000000000 out=%h lat=%0d", dif.out, lat);
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    n_cmp++; if (dif.in_ready !== 1'b1)  begin n_bad++; $display("FAIL b2b_idle_in_ready got=%b want=1", dif.in_ready); end
    n_cmp++; if (dif.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_out_valid got=%b want=0", dif.out_valid); end
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    n_cmp++; if (dif.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_busy got=%b want=1", dif.busy); end
    lat = 1;
    while (!dif.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (dif.out !== 64'h4008000000000000) begin n_bad++; $display("FAIL b2b_second_out got=%h want=4008000000000000", dif.out); end
    n_cmp++; if (lat != 56) begin n_bad++; $display("FAIL b2b_second_latency got=%0d want=56", lat); end
    $display("op b2b second a=4018000000000000 b=4000000000000000 out=%h lat=%0d", dif.out, lat);
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
